// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN window datapath: kernel size, window
// packing index and the frame sequencer state encoding.
package cnn_pkg;

    localparam int KSIZE = 3;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        DONE
    } win_state_t;

    // Flat position of window element (r,c); r=0 is the top row, c=0 the left column
    function automatic int win_idx(input int r, input int c);
        return KSIZE * r + c;
    endfunction

endpackage

// File: rtl/cnn_line_buffer.sv
// One image row of pixel storage, addressed by the shared column pointer.
// Read is asynchronous so the old entry is available in the same cycle
// it gets overwritten; storage has no reset and maps to distributed RAM.
module cnn_line_buffer
    import cnn_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Overwrite the entry at the column pointer when a pixel is absorbed
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/cnn_window_gen.sv
// Streaming 3x3 sliding-window generator. Walks the image ROM in raster
// order, keeps the two previous rows in line buffers and presents every
// fully populated 3x3 neighbourhood under a valid/ready handshake.
// Optional build macro CNN_WIN_COORD_EN adds out_row/out_col carrying the
// top-left anchor of each emitted window.
module cnn_window_gen
    import cnn_pkg::*;
#(
    parameter int PIX_WIDTH = 4,
    parameter int IMG_W     = 32,
    parameter int IMG_H     = 32
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    output logic                               busy,
    output logic                               done,
    output logic [$clog2(IMG_W*IMG_H)-1:0]     rom_addr,
    input  logic [PIX_WIDTH-1:0]               rom_data,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [KSIZE*KSIZE*PIX_WIDTH-1:0]   out_win
`ifdef CNN_WIN_COORD_EN
    ,
    output logic [$clog2(IMG_H)-1:0]           out_row,
    output logic [$clog2(IMG_W)-1:0]           out_col
`endif
);

    localparam int NPIX = IMG_W * IMG_H;
    localparam int AW   = $clog2(NPIX);
    localparam int CW   = $clog2(IMG_W);
    localparam int RW   = $clog2(IMG_H);

    win_state_t state;

    logic                 adv;
    logic                 rom_vld;
    logic                 rom_stalled;
    logic [PIX_WIDTH-1:0] rom_hold;
    logic [PIX_WIDTH-1:0] rom_pix;
    logic                 pix_vld;
    logic [PIX_WIDTH-1:0] pix_q;
    logic [CW-1:0]        col;
    logic [RW-1:0]        row;
    logic                 absorb;
    logic                 win_ok;
    logic                 win_last_pix;
    logic                 out_last;
    logic [PIX_WIDTH-1:0] lb1_rd;
    logic [PIX_WIDTH-1:0] lb2_rd;
    logic [PIX_WIDTH-1:0] win [KSIZE][KSIZE];

    assign adv          = !(out_valid && !out_ready);
    assign absorb       = adv && pix_vld;
    assign win_ok       = (row >= RW'(2)) && (col >= CW'(2));
    assign win_last_pix = (row == RW'(IMG_H - 1)) && (col == CW'(IMG_W - 1));

    // The ROM keeps re-reading the held address during a stall, which would
    // replace the pixel still in flight; rom_hold keeps that pixel instead.
    assign rom_pix = rom_stalled ? rom_hold : rom_data;

    // Frame sequencer: address generation, busy/done flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            rom_addr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= FETCH;
                        busy     <= 1'b1;
                        rom_addr <= '0;
                    end
                end
                FETCH: begin
                    if (adv) begin
                        if (rom_addr == AW'(NPIX - 1)) begin
                            state <= DRAIN;
                        end else begin
                            rom_addr <= rom_addr + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (out_valid && out_ready && out_last) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    done     <= 1'b0;
                    busy     <= 1'b0;
                    rom_addr <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Pixel pipeline from ROM output to the absorb stage, frozen by stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_stalled <= 1'b0;
            rom_hold    <= '0;
            rom_vld     <= 1'b0;
            pix_vld     <= 1'b0;
            pix_q       <= '0;
        end else begin
            rom_stalled <= !adv;
            rom_hold    <= rom_pix;
            if (adv) begin
                rom_vld <= (state == FETCH);
                pix_vld <= rom_vld;
                pix_q   <= rom_pix;
            end
        end
    end

    // Row/column position of the pixel being absorbed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row <= '0;
            col <= '0;
        end else if (state == IDLE && start) begin
            row <= '0;
            col <= '0;
        end else if (absorb) begin
            if (col == CW'(IMG_W - 1)) begin
                col <= '0;
                row <= row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    cnn_line_buffer #(
        .DEPTH (IMG_W),
        .WIDTH (PIX_WIDTH)
    ) u_lb1 (
        .clk   (clk),
        .wr_en (absorb),
        .addr  (col),
        .wdata (pix_q),
        .rdata (lb1_rd)
    );

    cnn_line_buffer #(
        .DEPTH (IMG_W),
        .WIDTH (PIX_WIDTH)
    ) u_lb2 (
        .clk   (clk),
        .wr_en (absorb),
        .addr  (col),
        .wdata (lb1_rd),
        .rdata (lb2_rd)
    );

    // Shift a new column {two rows up, one row up, current} into the window
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < KSIZE; r++) begin
                for (int c = 0; c < KSIZE; c++) begin
                    win[r][c] <= '0;
                end
            end
        end else if (absorb) begin
            for (int r = 0; r < KSIZE; r++) begin
                for (int c = 0; c < KSIZE - 1; c++) begin
                    win[r][c] <= win[r][c+1];
                end
            end
            win[0][KSIZE-1] <= lb2_rd;
            win[1][KSIZE-1] <= lb1_rd;
            win[2][KSIZE-1] <= pix_q;
        end
    end

    // Window valid once a full neighbourhood sits in the register; wrap columns excluded
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (adv) begin
            out_valid <= pix_vld && win_ok;
            out_last  <= pix_vld && win_last_pix;
        end
    end

`ifdef CNN_WIN_COORD_EN
    // Anchor coordinate travels with the window it describes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_row <= '0;
            out_col <= '0;
        end else if (absorb && win_ok) begin
            out_row <= row - RW'(2);
            out_col <= col - CW'(2);
        end
    end
`endif

    // Flatten the window register into the packed output bus
    always_comb begin
        out_win = '0;
        for (int r = 0; r < KSIZE; r++) begin
            for (int c = 0; c < KSIZE; c++) begin
                out_win[PIX_WIDTH*win_idx(r, c) +: PIX_WIDTH] = win[r][c];
            end
        end
    end

endmodule

// File: tb/tb_cnn_window_gen.sv
// Directed bench for cnn_window_gen: an 8x8 instance (full/stalled/
// restarted/reset frames) and a 3x3 instance (minimum image). Expected
// windows are queued when a frame starts and popped on each handshake.
module tb_cnn_window_gen;

    localparam int PW = 8;
    localparam int W  = 8;
    localparam int H  = 8;
    localparam int W3 = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        busy;
    logic        done;
    logic [5:0]  romAddr;
    logic [7:0]  romData;
    logic        outValid;
    logic        outReady;
    logic [71:0] outWin;

    logic        start3;
    logic        busy3;
    logic        done3;
    logic [3:0]  romAddr3;
    logic [7:0]  romData3;
    logic        outValid3;
    logic        outReady3;
    logic [71:0] outWin3;

`ifdef CNN_WIN_COORD_EN
    logic [2:0]  outRow;
    logic [2:0]  outCol;
    logic [1:0]  outRow3;
    logic [1:0]  outCol3;
    logic [5:0]  coordQ[$];
`endif

    int          nCompared   = 0;
    int          nMismatched = 0;
    int          winCount    = 0;
    int          doneCount   = 0;
    int          winCount3   = 0;
    int          doneCount3  = 0;
    logic [71:0] sbQueue[$];
    logic [71:0] sbQueue3[$];

    always #5 clk = ~clk;

    // Image ROMs holding ROM[i] = i with a one-cycle registered read
    always @(posedge clk) romData <= PW'(romAddr);
    always @(posedge clk) romData3 <= PW'(romAddr3);

    cnn_window_gen #(
        .PIX_WIDTH (PW),
        .IMG_W     (W),
        .IMG_H     (H)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .rom_addr  (romAddr),
        .rom_data  (romData),
        .out_valid (outValid),
        .out_ready (outReady),
        .out_win   (outWin)
`ifdef CNN_WIN_COORD_EN
        ,
        .out_row   (outRow),
        .out_col   (outCol)
`endif
    );

    cnn_window_gen #(
        .PIX_WIDTH (PW),
        .IMG_W     (W3),
        .IMG_H     (W3)
    ) dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start3),
        .busy      (busy3),
        .done      (done3),
        .rom_addr  (romAddr3),
        .rom_data  (romData3),
        .out_valid (outValid3),
        .out_ready (outReady3),
        .out_win   (outWin3)
`ifdef CNN_WIN_COORD_EN
        ,
        .out_row   (outRow3),
        .out_col   (outCol3)
`endif
    );

    // Window anchored at (ar,ac) in a w-wide image with ROM[i] = i
    function automatic logic [71:0] expWin(input int w, input int ar, input int ac);
        logic [71:0] v;
        v = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                v[PW*(3*r+c) +: PW] = PW'((ar + r) * w + ac + c);
            end
        end
        return v;
    endfunction

    task automatic checkOutput(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        nCompared++;
        assert (obs === exp) else begin
            nMismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // 8x8 monitor: scoreboard pops on handshake, hold check during stalls
    initial begin : monitor8
        logic        stallPrev;
        logic [71:0] stallWin;
        logic [71:0] expW;
        stallPrev = 1'b0;
        stallWin  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stallPrev = 1'b0;
            end else begin
                if (stallPrev) begin
                    checkOutput("stall_valid", 72'(outValid), 72'(1));
                    checkOutput("stall_win", outWin, stallWin);
                end
                if (outValid && outReady) begin
                    winCount++;
                    if (sbQueue.size() == 0) begin
                        checkOutput("extra_win", 72'(winCount), 72'(0));
                    end else begin
                        expW = sbQueue.pop_front();
                        checkOutput("win", outWin, expW);
                    end
`ifdef CNN_WIN_COORD_EN
                    if (coordQ.size() != 0) begin
                        expW = 72'(coordQ.pop_front());
                        checkOutput("out_row", 72'(outRow), 72'(expW[5:3]));
                        checkOutput("out_col", 72'(outCol), 72'(expW[2:0]));
                    end
`endif
                end
                if (done) doneCount++;
                stallPrev = outValid && !outReady;
                stallWin  = outWin;
            end
        end
    end

    // 3x3 monitor
    initial begin : monitor3
        logic [71:0] expW;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (outValid3 && outReady3) begin
                    winCount3++;
                    if (sbQueue3.size() == 0) begin
                        checkOutput("extra_win3", 72'(winCount3), 72'(0));
                    end else begin
                        expW = sbQueue3.pop_front();
                        checkOutput("win3", outWin3, expW);
                    end
`ifdef CNN_WIN_COORD_EN
                    checkOutput("out_row3", 72'(outRow3), 72'(0));
                    checkOutput("out_col3", 72'(outCol3), 72'(0));
`endif
                end
                if (done3) doneCount3++;
            end
        end
    end

    // Runs one 8x8 frame; optional random ready, mid-frame start or reset at window N
    task automatic applyStimulus(input bit randReady, input int midStartAt,
                                 input int resetAtWin, input bit checkFirst);
        int n;
        int firstSeen;
        int baseWin;
        int baseDone;
        bit doneSeen;
        bit aborted;
        sbQueue.delete();
`ifdef CNN_WIN_COORD_EN
        coordQ.delete();
`endif
        for (int ar = 0; ar < H - 2; ar++) begin
            for (int ac = 0; ac < W - 2; ac++) begin
                sbQueue.push_back(expWin(W, ar, ac));
`ifdef CNN_WIN_COORD_EN
                coordQ.push_back({3'(ar), 3'(ac)});
`endif
            end
        end
        baseWin  = winCount;
        baseDone = doneCount;
        outReady = 1'b1;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checkOutput("busy_after_start", 72'(busy), 72'(1));
        checkOutput("addr_after_start", 72'(romAddr), 72'(0));
        n         = 0;
        firstSeen = -1;
        doneSeen  = 1'b0;
        aborted   = 1'b0;
        while (!doneSeen && !aborted && n < 3000) begin
            if (outValid && firstSeen < 0) firstSeen = n;
            if (done) begin
                doneSeen = 1'b1;
                checkOutput("busy_with_done", 72'(busy), 72'(1));
            end else if (resetAtWin >= 0 && (winCount - baseWin) >= resetAtWin) begin
                rst_n = 1'b0;
                #2;
                checkOutput("rst_busy", 72'(busy), 72'(0));
                checkOutput("rst_done", 72'(done), 72'(0));
                checkOutput("rst_valid", 72'(outValid), 72'(0));
                checkOutput("rst_addr", 72'(romAddr), 72'(0));
                checkOutput("rst_win", outWin, 72'(0));
                sbQueue.delete();
`ifdef CNN_WIN_COORD_EN
                coordQ.delete();
`endif
                aborted = 1'b1;
                @(posedge clk); #1;
                rst_n = 1'b1;
            end else begin
                outReady = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
                start    = (n == midStartAt);
                @(posedge clk); #1;
                n++;
            end
        end
        start    = 1'b0;
        outReady = 1'b1;
        if (!aborted) begin
            checkOutput("done_seen", 72'(doneSeen), 72'(1));
            @(posedge clk); #1;
            checkOutput("done_cleared", 72'(done), 72'(0));
            checkOutput("busy_cleared", 72'(busy), 72'(0));
            checkOutput("win_count", 72'(winCount - baseWin), 72'((W - 2) * (H - 2)));
            checkOutput("done_count", 72'(doneCount - baseDone), 72'(1));
            checkOutput("sb_left", 72'(sbQueue.size()), 72'(0));
            if (checkFirst) checkOutput("first_valid_cycle", 72'(firstSeen), 72'(2 * W + 5));
        end
    endtask

    initial begin : stimulus
        int n3;
        int first3;
        bit doneSeen3;

        rst_n     = 1'b0;
        start     = 1'b0;
        start3    = 1'b0;
        outReady  = 1'b1;
        outReady3 = 1'b1;
        #12;
        checkOutput("reset_busy", 72'(busy), 72'(0));
        checkOutput("reset_done", 72'(done), 72'(0));
        checkOutput("reset_valid", 72'(outValid), 72'(0));
        checkOutput("reset_addr", 72'(romAddr), 72'(0));
        checkOutput("reset_win", outWin, 72'(0));
        checkOutput("reset_valid3", 72'(outValid3), 72'(0));
        checkOutput("reset_busy3", 72'(busy3), 72'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;

        $display("[TB] frame with out_ready held high");
        applyStimulus(1'b0, -1, -1, 1'b1);
        $display("[TB] frame with random out_ready");
        applyStimulus(1'b1, -1, -1, 1'b0);
        $display("[TB] frame with start pulsed mid-frame");
        applyStimulus(1'b0, 30, -1, 1'b0);
        $display("[TB] reset at window 10, then full frame");
        applyStimulus(1'b0, -1, 10, 1'b0);
        applyStimulus(1'b0, -1, -1, 1'b1);

        $display("[TB] minimum 3x3 image");
        sbQueue3.delete();
        sbQueue3.push_back(expWin(W3, 0, 0));
        @(posedge clk); #1;
        start3 = 1'b1;
        @(posedge clk); #1;
        start3    = 1'b0;
        n3        = 0;
        first3    = -1;
        doneSeen3 = 1'b0;
        while (!doneSeen3 && n3 < 200) begin
            if (outValid3 && first3 < 0) first3 = n3;
            if (done3) begin
                doneSeen3 = 1'b1;
            end else begin
                @(posedge clk); #1;
                n3++;
            end
        end
        checkOutput("done_seen3", 72'(doneSeen3), 72'(1));
        @(posedge clk); #1;
        checkOutput("first_valid_cycle3", 72'(first3), 72'(2 * W3 + 5));
        checkOutput("win_count3", 72'(winCount3), 72'(1));
        checkOutput("done_count3", 72'(doneCount3), 72'(1));
        checkOutput("busy_cleared3", 72'(busy3), 72'(0));
        checkOutput("sb_left3", 72'(sbQueue3.size()), 72'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
